// File: rtl/awsf1_sda_pkg.sv
// Shared types and constants for the SDA AXI-Lite to register-bus bridge.
package awsf1_sda_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP
  } sda_state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } sda_grant_e;

  localparam logic [1:0]  RESP_OKAY       = 2'b00;
  localparam logic [1:0]  RESP_SLVERR     = 2'b10;
  localparam int          DEF_TIMEOUT_CYC = 255;
  localparam logic [31:0] TIMEOUT_RDATA   = 32'hDEAD_BEEF;

  function automatic logic [1:0] resp_code(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/awsf1_sda_hold.sv
// One-entry valid/ready capture register; ready is registered (low in reset) and
// the entry is held until clr, refilling no earlier than the cycle after clr.
module awsf1_sda_hold #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  input  logic         clr,
  output logic         full,
  output logic [W-1:0] dat
);

  logic         full_q, full_d;
  logic         rdy_q, rdy_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    full_d = full_q;
    dat_d  = dat_q;
    if (clr) begin
      full_d = 1'b0;
    end
    if (in_vld && rdy_q) begin
      full_d = 1'b1;
      dat_d  = in_dat;
    end
    rdy_d = ~full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      rdy_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      rdy_q  <= rdy_d;
      dat_q  <= dat_d;
    end
  end

  assign in_rdy = rdy_q;
  assign full   = full_q;
  assign dat    = dat_q;

endmodule

// File: rtl/awsf1_sda_ctrl.sv
// AXI-Lite (SDA) to single-outstanding register-bus bridge; reg_req 1 cycle after grant,
// response 1 cycle after reg_ack. Optional request timeout under SDA_TIMEOUT_EN.
module awsf1_sda_ctrl
  import awsf1_sda_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk_main_a0,
  input  logic                rst_main_n,
  input  logic                sda_awvalid,
  input  logic [ADDR_W-1:0]   sda_awaddr,
  output logic                sda_awready,
  input  logic                sda_wvalid,
  input  logic [DATA_W-1:0]   sda_wdata,
  input  logic [DATA_W/8-1:0] sda_wstrb,
  output logic                sda_wready,
  output logic                sda_bvalid,
  output logic [1:0]          sda_bresp,
  input  logic                sda_bready,
  input  logic                sda_arvalid,
  input  logic [ADDR_W-1:0]   sda_araddr,
  output logic                sda_arready,
  output logic                sda_rvalid,
  output logic [DATA_W-1:0]   sda_rdata,
  output logic [1:0]          sda_rresp,
  input  logic                sda_rready,
  output logic                reg_req,
  output logic                reg_we,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [DATA_W/8-1:0] reg_wstrb,
  input  logic                reg_ack,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic                reg_err
);

  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  sda_state_e  state_q, state_d;
  sda_grant_e  last_grant_q, last_grant_d;
  logic        run_q;

  logic                     aw_full, w_full, hold_clr;
  logic [ADDR_W-1:0]        aw_dat;
  logic [STRB_W+DATA_W-1:0] w_dat;
  logic                     wr_pend, rd_pend, pick_wr, pick_rd, tmo_fire;

  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic [STRB_W-1:0] reg_wstrb_q, reg_wstrb_d;
  logic              reg_we_q, reg_we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;

  awsf1_sda_hold #(.W(ADDR_W)) u_aw_hold (
    .clk    (clk_main_a0),
    .rst_n  (rst_main_n),
    .in_vld (sda_awvalid),
    .in_dat (sda_awaddr),
    .in_rdy (sda_awready),
    .clr    (hold_clr),
    .full   (aw_full),
    .dat    (aw_dat)
  );

  awsf1_sda_hold #(.W(STRB_W + DATA_W)) u_w_hold (
    .clk    (clk_main_a0),
    .rst_n  (rst_main_n),
    .in_vld (sda_wvalid),
    .in_dat ({sda_wstrb, sda_wdata}),
    .in_rdy (sda_wready),
    .clr    (hold_clr),
    .full   (w_full),
    .dat    (w_dat)
  );

  // run_q keeps the combinational arready low while in reset.
  assign wr_pend = aw_full && w_full;
  assign rd_pend = sda_arvalid && run_q;

  always_comb begin
    pick_rd = rd_pend && (!wr_pend || (last_grant_q == GRANT_WR));
    pick_wr = wr_pend && !pick_rd;
  end

`ifdef SDA_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             in_req;

  // Count is 0 in the first request cycle, so the timeout lands on request cycle TIMEOUT_CYC.
  always_comb begin
    in_req    = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
    tmo_cnt_d = in_req ? tmo_cnt_q + CNT_W'(1) : '0;
    tmo_fire  = in_req && (tmo_cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_wstrb_d  = reg_wstrb_q;
    reg_we_d     = reg_we_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_wr) begin
          state_d     = ST_WR_REQ;
          reg_addr_d  = aw_dat;
          reg_wdata_d = w_dat[DATA_W-1:0];
          reg_wstrb_d = w_dat[DATA_W +: STRB_W];
          reg_we_d    = 1'b1;
          if (rd_pend) last_grant_d = GRANT_WR;
        end else if (pick_rd) begin
          state_d     = ST_RD_REQ;
          reg_addr_d  = sda_araddr;
          reg_wdata_d = '0;
          reg_wstrb_d = '0;
          reg_we_d    = 1'b0;
          if (wr_pend) last_grant_d = GRANT_RD;
        end
      end
      ST_WR_REQ: begin
        if (reg_ack) begin
          state_d = ST_WR_RESP;
          resp_d  = resp_code(reg_err);
        end else if (tmo_fire) begin
          state_d = ST_WR_RESP;
          resp_d  = RESP_SLVERR;
        end
      end
      ST_RD_REQ: begin
        if (reg_ack) begin
          state_d = ST_RD_RESP;
          resp_d  = resp_code(reg_err);
          rdata_d = reg_rdata;
        end else if (tmo_fire) begin
          state_d = ST_RD_RESP;
          resp_d  = RESP_SLVERR;
          rdata_d = DATA_W'(TIMEOUT_RDATA);
        end
      end
      ST_WR_RESP: if (sda_bready) state_d = ST_IDLE;
      ST_RD_RESP: if (sda_rready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_RD;
      run_q        <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_wstrb_q  <= '0;
      reg_we_q     <= 1'b0;
      rdata_q      <= '0;
      resp_q       <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      run_q        <= 1'b1;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_wstrb_q  <= reg_wstrb_d;
      reg_we_q     <= reg_we_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
    end
  end

  always_comb begin
    reg_req     = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
    sda_bvalid  = (state_q == ST_WR_RESP);
    sda_rvalid  = (state_q == ST_RD_RESP);
    sda_arready = (state_q == ST_IDLE) && pick_rd;
    hold_clr    = (state_q == ST_WR_RESP) && sda_bready;
  end

  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wstrb = reg_wstrb_q;
  assign sda_bresp = resp_q;
  assign sda_rresp = resp_q;
  assign sda_rdata = rdata_q;

endmodule

// File: tb/tb_awsf1_sda_ctrl.sv
// Directed bench for awsf1_sda_ctrl; timeout vectors run when SDA_TIMEOUT_EN is defined.
module tb_awsf1_sda_ctrl;

  logic        clk_main_a0 = 1'b0;
  logic        rst_main_n  = 1'b0;
  logic        sda_awvalid, sda_awready, sda_wvalid, sda_wready;
  logic [31:0] sda_awaddr, sda_wdata;
  logic [3:0]  sda_wstrb;
  logic        sda_bvalid, sda_bready;
  logic [1:0]  sda_bresp;
  logic        sda_arvalid, sda_arready, sda_rvalid, sda_rready;
  logic [31:0] sda_araddr, sda_rdata;
  logic [1:0]  sda_rresp;
  logic        reg_req, reg_we, reg_ack, reg_err;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic [3:0]  reg_wstrb;

  int n_chk  = 0;
  int n_pass = 0;

  logic [127:0] all_outs;
  assign all_outs = 128'({sda_awready, sda_wready, sda_bvalid, sda_bresp, sda_arready,
                          sda_rvalid, sda_rdata, sda_rresp, reg_req, reg_we, reg_addr,
                          reg_wdata, reg_wstrb});

  awsf1_sda_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(255)) dut (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .sda_awvalid (sda_awvalid),
    .sda_awaddr  (sda_awaddr),
    .sda_awready (sda_awready),
    .sda_wvalid  (sda_wvalid),
    .sda_wdata   (sda_wdata),
    .sda_wstrb   (sda_wstrb),
    .sda_wready  (sda_wready),
    .sda_bvalid  (sda_bvalid),
    .sda_bresp   (sda_bresp),
    .sda_bready  (sda_bready),
    .sda_arvalid (sda_arvalid),
    .sda_araddr  (sda_araddr),
    .sda_arready (sda_arready),
    .sda_rvalid  (sda_rvalid),
    .sda_rdata   (sda_rdata),
    .sda_rresp   (sda_rresp),
    .sda_rready  (sda_rready),
    .reg_req     (reg_req),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wstrb   (reg_wstrb),
    .reg_ack     (reg_ack),
    .reg_rdata   (reg_rdata),
    .reg_err     (reg_err)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_main_a0);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sda_awvalid = 0; sda_awaddr = 0; sda_wvalid = 0; sda_wdata = 0; sda_wstrb = 0;
    sda_bready  = 0; sda_arvalid = 0; sda_araddr = 0; sda_rready = 0;
    reg_ack     = 0; reg_rdata = 0; reg_err = 0;

    tick(2);
    chk("rst_outs", all_outs, 128'h0);
    rst_main_n = 1;
    tick(3);
    chk("idle_rdy", {sda_awready, sda_wready, sda_arready}, 3'b110);

    // AW in cycle 0, W in cycle 3, request expected in cycle 5, ack in cycle 7.
    sda_awvalid = 1; sda_awaddr = 32'h20;
    tick; sda_awvalid = 0;
    chk("aw_held_rdy", sda_awready, 1'b0);
    tick(2);
    sda_wvalid = 1; sda_wdata = 32'hA5A5_0001; sda_wstrb = 4'hF;
    tick; sda_wvalid = 0;
    chk("wr_c4_req", reg_req, 1'b0);
    tick;
    chk("wr_c5_req", {reg_req, reg_we}, 2'b11);
    chk("wr_c5_addr", reg_addr, 32'h20);
    chk("wr_c5_data", {reg_wstrb, reg_wdata}, {4'hF, 32'hA5A5_0001});
    tick(2);
    reg_ack = 1;
    chk("wr_c7_stable", {sda_bvalid, reg_req, reg_we, reg_addr}, {1'b0, 1'b1, 1'b1, 32'h20});
    tick; reg_ack = 0;
    chk("wr_bresp", {sda_bvalid, sda_bresp, reg_req}, {1'b1, 2'b00, 1'b0});
    sda_bready = 1;
    tick; sda_bready = 0;
    chk("wr_done", {sda_bvalid, sda_awready, sda_wready}, 3'b011);

    reg_ack = 1;
    tick; reg_ack = 0;
    chk("stray_ack", {sda_bvalid, sda_rvalid, reg_req}, 3'b000);

    sda_arvalid = 1; sda_araddr = 32'h10; #1;
    chk("rd_arready", sda_arready, 1'b1);
    tick; sda_arvalid = 0;
    chk("rd_req", {reg_req, reg_we, reg_addr}, {1'b1, 1'b0, 32'h10});
    reg_rdata = 32'h1234_5678; reg_ack = 1;
    tick; reg_ack = 0; reg_rdata = 0;
    chk("rd_resp", {sda_rvalid, sda_rresp, sda_rdata}, {1'b1, 2'b00, 32'h1234_5678});
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rd_hold", {sda_rvalid, sda_rdata}, {1'b1, 32'h1234_5678});
    end
    sda_rready = 1;
    tick; sda_rready = 0;
    chk("rd_done", sda_rvalid, 1'b0);

    sda_awvalid = 1; sda_awaddr = 32'h30; sda_wvalid = 1; sda_wdata = 32'h3333; sda_wstrb = 4'h3;
    tick; sda_awvalid = 0; sda_wvalid = 0;
    tick;
    chk("err_req", {reg_req, reg_we, reg_wstrb}, {1'b1, 1'b1, 4'h3});
    reg_ack = 1; reg_err = 1;
    tick; reg_ack = 0; reg_err = 0;
    chk("err_bresp", {sda_bvalid, sda_bresp}, {1'b1, 2'b10});
    sda_bready = 1;
    tick; sda_bready = 0;

    // First conflict since reset: write wins.
    sda_awvalid = 1; sda_wvalid = 1; sda_awaddr = 32'h40; sda_wdata = 32'h4040; sda_wstrb = 4'hF;
    tick; sda_awvalid = 0; sda_wvalid = 0;
    sda_arvalid = 1; sda_araddr = 32'h44; #1;
    chk("cf1_arready", sda_arready, 1'b0);
    tick;
    chk("cf1_grant", {reg_req, reg_we, reg_addr}, {1'b1, 1'b1, 32'h40});
    reg_ack = 1;
    tick; reg_ack = 0;
    chk("cf1_bvalid", sda_bvalid, 1'b1);
    sda_bready = 1;
    tick; sda_bready = 0;
    sda_awvalid = 1; sda_wvalid = 1; sda_awaddr = 32'h50; sda_wdata = 32'h5050; #1;
    chk("cf_rd_arready", sda_arready, 1'b1);
    tick; sda_awvalid = 0; sda_wvalid = 0; sda_araddr = 32'h48;
    chk("cf_rd_req", {reg_req, reg_we, reg_addr}, {1'b1, 1'b0, 32'h44});
    chk("wr_during_rd", {sda_awready, sda_wready}, 2'b00);
    reg_ack = 1; reg_rdata = 32'h44;
    tick; reg_ack = 0;
    sda_rready = 1;
    tick; sda_rready = 0; #1;
    // Second conflict: read wins.
    chk("cf2_arready", sda_arready, 1'b1);
    tick; sda_arvalid = 0;
    chk("cf2_grant", {reg_req, reg_we, reg_addr}, {1'b1, 1'b0, 32'h48});
    reg_ack = 1;
    tick; reg_ack = 0;
    sda_rready = 1;
    tick; sda_rready = 0;
    tick;
    chk("cf2_wr_after", {reg_req, reg_we, reg_addr, reg_wdata}, {1'b1, 1'b1, 32'h50, 32'h5050});
    reg_ack = 1;
    tick; reg_ack = 0;
    sda_bready = 1;
    tick; sda_bready = 0;

    sda_arvalid = 1; sda_araddr = 32'h60;
    tick; sda_arvalid = 0;
    chk("rst_pre", reg_req, 1'b1);
    #2; rst_main_n = 0; #1;
    chk("rst_async", all_outs, 128'h0);
    tick(2);
    #2; rst_main_n = 1;
    tick(3);
    chk("rst_no_resp", {sda_rvalid, reg_req}, 2'b00);
    sda_arvalid = 1; sda_araddr = 32'h10;
    tick; sda_arvalid = 0;
    chk("post_rst_req", {reg_req, reg_addr}, {1'b1, 32'h10});
    reg_rdata = 32'hCAFE_F00D; reg_ack = 1;
    tick; reg_ack = 0;
    chk("post_rst_resp", {sda_rvalid, sda_rresp, sda_rdata}, {1'b1, 2'b00, 32'hCAFE_F00D});
    sda_rready = 1;
    tick; sda_rready = 0;

`ifdef SDA_TIMEOUT_EN
    sda_arvalid = 1; sda_araddr = 32'h70;
    tick; sda_arvalid = 0;
    n = 0;
    while (reg_req && n < 1000) begin
      n++;
      tick;
    end
    chk("tmo_len", n, 255);
    chk("tmo_resp", {sda_rvalid, sda_rresp, sda_rdata}, {1'b1, 2'b10, 32'hDEAD_BEEF});
    sda_rready = 1;
    tick; sda_rready = 0;
    sda_arvalid = 1; sda_araddr = 32'h74;
    tick; sda_arvalid = 0;
    tick(254);
    chk("tmo_edge_req", reg_req, 1'b1);
    reg_ack = 1; reg_rdata = 32'h55AA_55AA;
    tick; reg_ack = 0;
    chk("tmo_edge_resp", {sda_rvalid, sda_rresp, sda_rdata}, {1'b1, 2'b00, 32'h55AA_55AA});
    sda_rready = 1;
    tick; sda_rready = 0;
`else
    sda_arvalid = 1; sda_araddr = 32'h70;
    tick; sda_arvalid = 0;
    n = 0;
    tick(300);
    chk("no_tmo_wait", {reg_req, sda_rvalid, n[0]}, 3'b100);
    reg_ack = 1; reg_rdata = 32'h0BAD_CAFE;
    tick; reg_ack = 0;
    chk("no_tmo_resp", {sda_rvalid, sda_rresp, sda_rdata}, {1'b1, 2'b00, 32'h0BAD_CAFE});
    sda_rready = 1;
    tick; sda_rready = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
